uart_cmd_engine: RTL and testbench

Parametrised UART command engine between the uart block's RX/TX FIFOs and the top-level control logic. It assembles fixed-length commands from the RX FIFO and matches them against a programmable command table. It pulses a decoded command ID and writes a 4-byte ASCII acknowledge into the TX FIFO. Successor to the hard-coded "TEST" string transmitter and command parser in the top module.

---
 rtl/uart_cmd_pkg.sv | 11 +
 rtl/uart_reply_seq.sv | 61 ++++++
 rtl/uart_cmd_engine.sv | 123 ++++++++++++
 tb/tb_uart_cmd_engine.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: state encoding and ASCII reply constants shared by the UART command engine
//   COLLECT - assembling command bytes from the RX FIFO
//   MATCH   - one-cycle parallel compare against the command table
//   REPLY   - pushing the 4-byte acknowledge into the TX FIFO
package uart_cmd_pkg;
    typedef enum logic [1:0] {COLLECT = 2'd0, MATCH = 2'd1, REPLY = 2'd2} state_t;
    localparam int REPLY_LEN = 4;
    // Byte 0 (first on the wire) sits in bits [7:0]
    localparam logic [REPLY_LEN*8-1:0] REPLY_OK = {8'h0A, 8'h0D, 8'h4B, 8'h4F};
    localparam logic [REPLY_LEN*8-1:0] REPLY_ER = {8'h0A, 8'h0D, 8'h52, 8'h45};
endpackage

// File: rtl/uart_reply_seq.sv
// uart_reply_seq: pushes a 4-byte reply into the TX FIFO, one byte every 2 cycles at most
//   clock, reset_n   : system clock, asynchronous active-low reset
//   i_start          : load i_reply and begin sending (1-cycle pulse)
//   i_reply          : reply bytes, byte 0 in bits [7:0]
//   i_echo           : push i_echo_data this cycle (echo path shares the TX mux)
//   i_echo_data      : byte to echo
//   i_tx_full        : TX FIFO full flag
//   o_tx_data        : byte to TX FIFO (holds last value)
//   o_tx_we          : TX FIFO push strobe, 1-cycle pulse
//   o_done           : 1-cycle pulse together with the last reply push
module uart_reply_seq
    import uart_cmd_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   i_start,
    input  logic [REPLY_LEN*8-1:0] i_reply,
    input  logic                   i_echo,
    input  logic [7:0]             i_echo_data,
    input  logic                   i_tx_full,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_we,
    output logic                   o_done
);
    localparam int RW = $clog2(REPLY_LEN);
    logic [REPLY_LEN*8-1:0] r_bytes;
    logic [RW-1:0]          r_idx;
    logic                   r_active;
    logic                   w_push;
    // The previous strobe doubles as the guard: the FIFO flag is one cycle stale after a push
    assign w_push = r_active && !i_tx_full && !o_tx_we;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bytes   <= '0;
            r_idx     <= '0;
            r_active  <= 1'b0;
            o_tx_data <= 8'h00;
            o_tx_we   <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_tx_we <= 1'b0;
            o_done  <= 1'b0;
            if (i_start) begin
                r_bytes  <= i_reply;
                r_idx    <= '0;
                r_active <= 1'b1;
            end else if (w_push) begin
                o_tx_we   <= 1'b1;
                o_tx_data <= r_bytes[r_idx*8 +: 8];
                r_idx     <= r_idx + 1'b1;
                if (r_idx == RW'(REPLY_LEN - 1)) begin
                    r_active <= 1'b0;
                    o_done   <= 1'b1;
                end
            end else if (i_echo) begin
                o_tx_we   <= 1'b1;
                o_tx_data <= i_echo_data;
            end
        end
    end
endmodule

// File: rtl/uart_cmd_engine.sv
// uart_cmd_engine: assembles fixed-length commands from the RX FIFO, matches them against a
// programmable table, pulses the decoded ID and answers "OK\r\n" / "ER\r\n" into the TX FIFO.
//   clock, reset_n            : system clock, asynchronous active-low reset
//   rx_fifo_empty/_data_out   : FWFT RX FIFO head;  rx_fifo_read_en : pop strobe
//   tx_fifo_full              : TX FIFO full;  tx_fifo_data_in/_write_en : push byte/strobe
//   cmd_table                 : entry k byte j at [(k*CMD_LEN+j)*8 +: 8]
//   cmd_valid/cmd_id          : match pulse and lowest matching entry (id held)
//   cmd_error                 : complete command, no match;  cmd_timeout : partial discarded
//   busy                      : high outside COLLECT
// Optional build macro UART_CMD_ECHO_EN: echo every popped byte to TX ahead of the reply.
module uart_cmd_engine
    import uart_cmd_pkg::*;
#(
    parameter int CMD_LEN        = 4,
    parameter int NUM_CMDS       = 4,
    parameter int TIMEOUT_CYCLES = 2700000,
    parameter int ID_W           = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        rx_fifo_empty,
    input  logic [7:0]                  rx_fifo_data_out,
    output logic                        rx_fifo_read_en,
    input  logic                        tx_fifo_full,
    output logic [7:0]                  tx_fifo_data_in,
    output logic                        tx_fifo_write_en,
    input  logic [NUM_CMDS*CMD_LEN*8-1:0] cmd_table,
    output logic                        cmd_valid,
    output logic [ID_W-1:0]             cmd_id,
    output logic                        cmd_error,
    output logic                        cmd_timeout,
    output logic                        busy
);
    localparam int IW = $clog2(CMD_LEN);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    state_t                 r_state;
    logic [IW-1:0]          r_idx;
    logic [TW-1:0]          r_tcnt;
    logic [CMD_LEN*8-1:0]   r_buf;
    logic                   w_pop;
    logic                   w_echo;
    logic                   w_tmo;
    logic                   w_hit;
    logic [ID_W-1:0]        w_hit_id;
    logic                   w_done;
    // rx_fifo_read_en is the RX guard: it blocks the cycle in which the empty flag is still stale
`ifdef UART_CMD_ECHO_EN
    assign w_pop  = (r_state == COLLECT) && !rx_fifo_empty && !rx_fifo_read_en
                    && !tx_fifo_full && !tx_fifo_write_en;
    assign w_echo = w_pop;
`else
    assign w_pop  = (r_state == COLLECT) && !rx_fifo_empty && !rx_fifo_read_en;
    assign w_echo = 1'b0;
`endif
    assign w_tmo = (TIMEOUT_CYCLES != 0) && (r_idx != '0) && (r_tcnt == TMAX);
    assign busy  = (r_state != COLLECT);
    // Scan from the top so the lowest matching entry is the one left standing
    always_comb begin
        w_hit    = 1'b0;
        w_hit_id = '0;
        for (int k = NUM_CMDS - 1; k >= 0; k--)
            if (r_buf == cmd_table[k*CMD_LEN*8 +: CMD_LEN*8]) begin
                w_hit    = 1'b1;
                w_hit_id = ID_W'(k);
            end
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= COLLECT;
            r_idx           <= '0;
            r_tcnt          <= '0;
            r_buf           <= '0;
            rx_fifo_read_en <= 1'b0;
            cmd_valid       <= 1'b0;
            cmd_id          <= '0;
            cmd_error       <= 1'b0;
            cmd_timeout     <= 1'b0;
        end else begin
            rx_fifo_read_en <= 1'b0;
            cmd_valid       <= 1'b0;
            cmd_error       <= 1'b0;
            cmd_timeout     <= 1'b0;
            case (r_state)
                COLLECT: begin
                    if (w_pop) begin
                        rx_fifo_read_en       <= 1'b1;
                        r_buf[r_idx*8 +: 8]   <= rx_fifo_data_out;
                        r_tcnt                <= '0;
                        r_idx                 <= (r_idx == IW'(CMD_LEN - 1)) ? '0 : r_idx + 1'b1;
                        r_state               <= (r_idx == IW'(CMD_LEN - 1)) ? MATCH : COLLECT;
                    end else if (w_tmo) begin
                        r_idx       <= '0;
                        r_tcnt      <= '0;
                        cmd_timeout <= 1'b1;
                    end else if (r_idx != '0 && TIMEOUT_CYCLES != 0) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                MATCH: begin
                    cmd_valid <= w_hit;
                    cmd_error <= !w_hit;
                    cmd_id    <= w_hit ? w_hit_id : cmd_id;
                    r_state   <= REPLY;
                end
                REPLY:   r_state <= w_done ? COLLECT : REPLY;
                default: r_state <= COLLECT;
            endcase
        end
    end
    uart_reply_seq u_reply (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_start    (r_state == MATCH),
        .i_reply    (w_hit ? REPLY_OK : REPLY_ER),
        .i_echo     (w_echo),
        .i_echo_data(rx_fifo_data_out),
        .i_tx_full  (tx_fifo_full),
        .o_tx_data  (tx_fifo_data_in),
        .o_tx_we    (tx_fifo_write_en),
        .o_done     (w_done)
    );
endmodule

// File: tb/tb_uart_cmd_engine.sv
// tb_uart_cmd_engine: self-checking bench with FWFT RX FIFO / TX sink models and a table reference model
module tb_uart_cmd_engine;
    localparam int TMO = 100;
`ifdef UART_CMD_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif
    localparam logic [31:0] OK_R = {8'h0A, 8'h0D, 8'h4B, 8'h4F};
    localparam logic [31:0] ER_R = {8'h0A, 8'h0D, 8'h52, 8'h45};
    localparam logic [31:0] C_TEST = 32'h54534554;
    localparam logic [31:0] C_LEDS = 32'h5344454C;
    localparam logic [31:0] C_ABCD = 32'h44434241;
    localparam logic [31:0] C_XXXX = 32'h58585858;
    localparam logic [31:0] C_TESX = 32'h58534554;
    localparam logic [31:0] C_DCBA = 32'h41424344;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         rx_fifo_empty = 1'b1;
    logic [7:0]   rx_fifo_data_out = 8'h00;
    logic         rx_fifo_read_en;
    logic         tx_fifo_full;
    logic [7:0]   tx_fifo_data_in;
    logic         tx_fifo_write_en;
    logic [127:0] cmd_table;
    logic         cmd_valid;
    logic [1:0]   cmd_id;
    logic         cmd_error;
    logic         cmd_timeout;
    logic         busy;
    logic         hold_full = 1'b0;
    logic         rnd_full = 1'b0;
    logic         rnd_en = 1'b0;
    logic         full_at_edge = 1'b0;

    logic [31:0]  tbl [4];
    logic [7:0]   alph [8];
    logic [7:0]   rx_q [$];
    logic [7:0]   tx_log [$];
    int n_chk = 0, n_fail = 0;
    int n_valid = 0, n_err = 0, n_tmo = 0, last_id = 0;
    int cyc = 0, cyc_rd = 0, cyc_evt = 0, cyc_we = 0, cyc_tmo = 0;
    bit want_we = 0, prev_rd = 0, prev_we = 0;

    typedef struct {
        logic [31:0] cmd;
        int          exp_id;
    } vec_t;
    vec_t vecs [6];

    assign tx_fifo_full = hold_full | rnd_full;
    always #5 clock = ~clock;

    uart_cmd_engine #(.CMD_LEN(4), .NUM_CMDS(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .rx_fifo_empty   (rx_fifo_empty),
        .rx_fifo_data_out(rx_fifo_data_out),
        .rx_fifo_read_en (rx_fifo_read_en),
        .tx_fifo_full    (tx_fifo_full),
        .tx_fifo_data_in (tx_fifo_data_in),
        .tx_fifo_write_en(tx_fifo_write_en),
        .cmd_table       (cmd_table),
        .cmd_valid       (cmd_valid),
        .cmd_id          (cmd_id),
        .cmd_error       (cmd_error),
        .cmd_timeout     (cmd_timeout),
        .busy            (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: the lowest table entry equal to the command, or -1
    function automatic int ref_match(input logic [31:0] c);
        for (int k = 0; k < 4; k++)
            if (tbl[k] == c) return k;
        return -1;
    endfunction

    always @(posedge clock) full_at_edge <= tx_fifo_full;

    // FIFO models and event monitors, evaluated mid-cycle
    always @(negedge clock) begin
        cyc++;
        if (rx_fifo_read_en) begin
            check("rx_pop_nonempty", 32'(rx_q.size() != 0), 1);
            check("rx_pop_spacing", 32'(prev_rd), 0);
            cyc_rd = cyc;
            if (rx_q.size() != 0) void'(rx_q.pop_front());
        end
        prev_rd = rx_fifo_read_en;
        rx_fifo_empty = (rx_q.size() == 0);
        rx_fifo_data_out = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        if (tx_fifo_write_en) begin
            check("tx_push_not_full", 32'(full_at_edge), 0);
            check("tx_push_spacing", 32'(prev_we), 0);
            tx_log.push_back(tx_fifo_data_in);
            if (want_we) begin
                cyc_we = cyc;
                want_we = 0;
            end
        end
        prev_we = tx_fifo_write_en;
        if (cmd_valid) begin
            n_valid++;
            last_id = int'(cmd_id);
        end
        if (cmd_error) n_err++;
        if (cmd_valid || cmd_error) begin
            cyc_evt = cyc;
            want_we = 1;
        end
        if (cmd_timeout) begin
            n_tmo++;
            cyc_tmo = cyc;
        end
        rnd_full = rnd_en && ($urandom_range(0, 3) == 0);
    end

    task automatic push_bytes(input logic [31:0] c, input int maxgap);
        for (int j = 0; j < 4; j++) begin
            rx_q.push_back(c[j*8 +: 8]);
            repeat ($urandom_range(0, maxgap)) @(negedge clock);
        end
    endtask

    task automatic wait_tx(input int n, input int budget);
        int t = 0;
        while (tx_log.size() < n && t < budget) begin
            @(negedge clock);
            t++;
        end
        if (tx_log.size() < n) check("tx_wait_expired", tx_log.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((busy || rx_q.size() != 0) && t < budget) begin
            @(negedge clock);
            t++;
        end
        if (busy) check("idle_wait_expired", 32'(busy), 0);
        repeat (2) @(negedge clock);
    endtask

    task automatic run_cmd(input string tag, input logic [31:0] c, input int exp_id,
                           input int maxgap, input bit chk_lat);
        logic [7:0]  exp_q [$];
        logic [31:0] rep;
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        tx_log.delete();
        if (ECHO) for (int j = 0; j < 4; j++) exp_q.push_back(c[j*8 +: 8]);
        rep = (exp_id >= 0) ? OK_R : ER_R;
        for (int j = 0; j < 4; j++) exp_q.push_back(rep[j*8 +: 8]);
        push_bytes(c, maxgap);
        wait_tx(exp_q.size(), 3000);
        wait_idle(200);
        check({tag, "_valid"}, n_valid - v0, (exp_id >= 0) ? 1 : 0);
        check({tag, "_error"}, n_err - e0, (exp_id >= 0) ? 0 : 1);
        if (exp_id >= 0) check({tag, "_id"}, last_id, exp_id);
        check({tag, "_txlen"}, tx_log.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < tx_log.size(); j++)
            check({tag, "_txbyte"}, tx_log[j], exp_q[j]);
        if (chk_lat) begin
            check({tag, "_lat_evt"}, cyc_evt - cyc_rd, 1);
            check({tag, "_lat_tx"}, cyc_we - cyc_evt, 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, v0, e0, t0, sz, mode;
        logic [31:0] c;
        logic [7:0]  exp_b [$];
        tbl[0] = C_TEST;
        tbl[1] = C_LEDS;
        tbl[2] = C_ABCD;
        tbl[3] = C_ABCD;
        cmd_table = {tbl[3], tbl[2], tbl[1], tbl[0]};
        alph = '{8'h54, 8'h45, 8'h53, 8'h4C, 8'h44, 8'h41, 8'h42, 8'h43};
        vecs[0] = '{C_TEST, 0};
        vecs[1] = '{C_XXXX, -1};
        vecs[2] = '{C_LEDS, 1};
        vecs[3] = '{C_ABCD, 2};
        vecs[4] = '{C_TESX, -1};
        vecs[5] = '{C_DCBA, -1};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_en", 32'(rx_fifo_read_en), 0);
        check("rst_we", 32'(tx_fifo_write_en), 0);
        check("rst_tx_data", 32'(tx_fifo_data_in), 0);
        check("rst_valid", 32'(cmd_valid), 0);
        check("rst_id", 32'(cmd_id), 0);
        check("rst_error", 32'(cmd_error), 0);
        check("rst_timeout", 32'(cmd_timeout), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Table-driven commands
        for (int i = 0; i < 6; i++)
            run_cmd($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].exp_id, 0, 1);

        // Partial command times out, then a full command parses from index 0
        tx_log.delete();
        v0 = n_valid;
        e0 = n_err;
        t0 = n_tmo;
        rx_q.push_back(8'h54);
        rx_q.push_back(8'h45);
        t = 0;
        while (n_tmo == t0 && t < 400) begin
            @(negedge clock);
            t++;
        end
        check("tmo_pulse", n_tmo - t0, 1);
        check("tmo_latency", cyc_tmo - cyc_rd, TMO);
        repeat (5) @(negedge clock);
        check("tmo_no_reply", tx_log.size(), ECHO ? 2 : 0);
        check("tmo_no_result", (n_valid - v0) + (n_err - e0), 0);
        check("tmo_busy", 32'(busy), 0);
        run_cmd("leds_after_tmo", C_LEDS, 1, 0, 1);

        // TX full stalls the reply; two queued commands, nothing lost
        tx_log.delete();
        v0 = n_valid;
        push_bytes(C_TEST, 0);
        push_bytes(C_TEST, 0);
        t = 0;
        while (!cmd_valid && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("full_first_valid", 32'(cmd_valid), 1);
        hold_full = 1'b1;
        repeat (50) @(negedge clock);
        check("full_stall_txlen", tx_log.size(), ECHO ? 4 : 0);
        check("full_stall_busy", 32'(busy), 1);
        check("full_rx_waits", rx_q.size(), 4);
        hold_full = 1'b0;
        wait_tx(ECHO ? 16 : 8, 2000);
        wait_idle(200);
        exp_b.delete();
        for (int r = 0; r < 2; r++) begin
            if (ECHO) for (int j = 0; j < 4; j++) exp_b.push_back(C_TEST[j*8 +: 8]);
            for (int j = 0; j < 4; j++) exp_b.push_back(OK_R[j*8 +: 8]);
        end
        check("full_valid_cnt", n_valid - v0, 2);
        check("full_txlen", tx_log.size(), exp_b.size());
        for (int j = 0; j < exp_b.size() && j < tx_log.size(); j++)
            check("full_txbyte", tx_log[j], exp_b[j]);

        // Duplicate entries resolve to the lower index; reset aborts mid-reply
        tx_log.delete();
        push_bytes(C_ABCD, 0);
        t = 0;
        while (tx_log.size() < (ECHO ? 6 : 2) && t < 300) begin
            @(negedge clock);
            t++;
        end
        check("abcd_id", last_id, 2);
        check("abcd_partial_tx", tx_log.size(), ECHO ? 6 : 2);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_we", 32'(tx_fifo_write_en), 0);
        check("midrst_tx_data", 32'(tx_fifo_data_in), 0);
        check("midrst_rd_en", 32'(rx_fifo_read_en), 0);
        check("midrst_valid", 32'(cmd_valid), 0);
        check("midrst_id", 32'(cmd_id), 0);
        @(negedge clock);
        reset_n = 1'b1;
        sz = tx_log.size();
        repeat (20) @(negedge clock);
        check("midrst_no_more_tx", tx_log.size(), sz);
        check("midrst_idle", 32'(busy), 0);
        run_cmd("leds_after_rst", C_LEDS, 1, 0, 1);

        // Randomized commands with random TX back-pressure against the reference model
        rnd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            mode = $urandom_range(0, 2);
            c = tbl[$urandom_range(0, 3)];
            if (mode == 1)
                for (int j = 0; j < 4; j++) c[j*8 +: 8] = alph[$urandom_range(0, 7)];
            else if (mode == 2)
                c[$urandom_range(0, 3)*8 +: 8] = alph[$urandom_range(0, 7)];
            run_cmd($sformatf("rnd%0d", i), c, ref_match(c), 6, 0);
        end
        rnd_en = 1'b0;
        repeat (4) @(negedge clock);
        check("total_timeouts", n_tmo, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
